// File: rtl/st7735_spi_tx.sv
`timescale 1ns/1ps
// st7735_spi_tx: byte-wide SPI mode 0 transmitter for ST7735 panel control lines.
// Build option: define ST7735_SPI_TX_FIFO_EN to add a 4-entry {dc,data} input FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | cs high, clk low, waiting for a word
// SHIFT_LO | oled_clk low half of the current bit, mosi presented
// SHIFT_HI | oled_clk high half; panel samples mosi on entry
module st7735_spi_tx #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_dc,
    output logic       busy,
    output logic       oled_cs,
    output logic       oled_clk,
    output logic       oled_mosi,
    output logic       oled_dc
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SHIFT_LO = 2'd1;
    localparam logic [1:0] ST_SHIFT_HI = 2'd2;
    localparam logic [7:0] DIV_LOAD    = 8'(CLK_DIV - 1);

    logic [1:0] r_state;
    logic [7:0] r_div;
    logic [2:0] r_bit;
    logic [7:0] r_shift;
    logic       r_dc;

    logic       w_div_tc;
    logic       w_word_end;
    logic       w_load_slot;
    logic       w_start;
    logic [7:0] w_next_data;
    logic       w_next_dc;

    // Divider counts down; the half-period ends on the cycle it reads zero.
    assign w_div_tc    = (r_div == 8'd0);
    assign w_word_end  = (r_state == ST_SHIFT_HI) && w_div_tc && (r_bit == 3'd0);
    // A new word may be loaded from idle or in the very last cycle of bit 0,
    // which is what lets consecutive words run without a cs gap.
    assign w_load_slot = (r_state == ST_IDLE) || w_word_end;

`ifdef ST7735_SPI_TX_FIFO_EN
    logic [8:0] r_fifo [0:3];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign in_ready = resetn && (r_count != 3'd4);
    assign w_push   = in_valid && in_ready;
    assign w_pop    = w_load_slot && (r_count != 3'd0);
    assign w_start  = w_pop;
    assign {w_next_dc, w_next_data} = r_fifo[r_rd_ptr];
    assign busy     = (r_state != ST_IDLE) || (r_count != 3'd0);

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {in_dc, in_data};
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count as is.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign in_ready    = resetn && w_load_slot;
    assign w_start     = in_valid && in_ready;
    assign w_next_data = in_data;
    assign w_next_dc   = in_dc;
    assign busy        = (r_state != ST_IDLE);
`endif

    // Shifter FSM: two divided half-periods per bit, MSB first, mosi moves on LO entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_div   <= 8'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_dc    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= ST_SHIFT_LO;
                        r_div   <= DIV_LOAD;
                        r_bit   <= 3'd7;
                        r_shift <= w_next_data;
                        r_dc    <= w_next_dc;
                    end
                end
                ST_SHIFT_LO: begin
                    if (w_div_tc) begin
                        r_state <= ST_SHIFT_HI;
                        r_div   <= DIV_LOAD;
                    end else begin
                        r_div <= r_div - 8'd1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (!w_div_tc) begin
                        r_div <= r_div - 8'd1;
                    end else if (r_bit != 3'd0) begin
                        r_state <= ST_SHIFT_LO;
                        r_div   <= DIV_LOAD;
                        r_bit   <= r_bit - 3'd1;
                        r_shift <= {r_shift[6:0], 1'b0};
                    end else if (w_start) begin
                        r_state <= ST_SHIFT_LO;
                        r_div   <= DIV_LOAD;
                        r_bit   <= 3'd7;
                        r_shift <= w_next_data;
                        r_dc    <= w_next_dc;
                    end else begin
                        r_state <= ST_IDLE;
                        r_div   <= 8'd0;
                        r_bit   <= 3'd0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_div   <= 8'd0;
                    r_bit   <= 3'd0;
                end
            endcase
        end
    end

    assign oled_cs   = (r_state == ST_IDLE);
    assign oled_clk  = (r_state == ST_SHIFT_HI);
    assign oled_mosi = r_shift[7];
    assign oled_dc   = r_dc;

endmodule
